// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared constants, types and 7-segment encodings for the result display
package calc_pkg;

    localparam int NUM_DIGITS  = 4;
    localparam int CONV_CYCLES = 7;

    // Active-low segment patterns, bit 0 = a ... bit 6 = g
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    localparam logic [9:0][6:0] SEG_DIGITS = {
        SEG_9, SEG_8, SEG_7, SEG_6, SEG_5, SEG_4, SEG_3, SEG_2, SEG_1, SEG_0
    };

    typedef enum logic {
        IDLE = 1'b0,
        CONV = 1'b1
    } state_t;

    typedef struct packed {
        logic       ovf;
        logic [3:0] w_tens;
        logic [3:0] w_ones;
        logic [3:0] f_tens;
        logic [3:0] f_ones;
    } disp_t;

endpackage

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - sequential 7-bit to two-digit BCD converter, one double-dabble shift per cycle
module bin2bcd_seq
    import calc_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [6:0] bin,
    output logic       done,
    output logic [3:0] tens,
    output logic [3:0] ones
);

    logic [6:0] bin_q, bin_d;
    logic [7:0] bcd_q, bcd_d;
    logic [2:0] cnt_q, cnt_d;
    logic       active_q, active_d;

    logic [3:0] tens_adj;
    logic [3:0] ones_adj;
    logic [7:0] bcd_shift;

    always_comb begin
        tens_adj  = (bcd_q[7:4] >= 4'd5) ? bcd_q[7:4] + 4'd3 : bcd_q[7:4];
        ones_adj  = (bcd_q[3:0] >= 4'd5) ? bcd_q[3:0] + 4'd3 : bcd_q[3:0];
        bcd_shift = {tens_adj[2:0], ones_adj, bin_q[6]};
    end

    always_comb begin
        bin_d    = bin_q;
        bcd_d    = bcd_q;
        cnt_d    = cnt_q;
        active_d = active_q;
        if (active_q) begin
            bin_d = {bin_q[5:0], 1'b0};
            bcd_d = bcd_shift;
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'(CONV_CYCLES - 1)) begin
                active_d = 1'b0;
            end
        end else if (start) begin
            bin_d    = bin;
            bcd_d    = 8'd0;
            cnt_d    = 3'd0;
            active_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bin_q    <= 7'd0;
            bcd_q    <= 8'd0;
            cnt_q    <= 3'd0;
            active_q <= 1'b0;
        end else begin
            bin_q    <= bin_d;
            bcd_q    <= bcd_d;
            cnt_q    <= cnt_d;
            active_q <= active_d;
        end
    end

    // Result is presented combinationally on the final shift so the caller can latch it that edge
    assign done = active_q && (cnt_q == 3'(CONV_CYCLES - 1));
    assign tens = bcd_shift[7:4];
    assign ones = bcd_shift[3:0];

endmodule

// File: rtl/result_display.sv
// rtl/result_display.sv - scanned 4-digit display of a square-root result; LEADING_ZERO_BLANK_EN blanks a zero whole-tens digit
module result_display
    import calc_pkg::*;
#(
    parameter int REFRESH_DIV = 100000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [6:0] whole,
    input  logic [6:0] fracture,
    output logic       busy,
    output logic [6:0] seg,
    output logic       dp,
    output logic [3:0] an
);

    localparam int CW = $clog2(REFRESH_DIV);

    state_t        state_q, state_d;
    logic          busy_q, busy_d;
    logic [6:0]    whole_q, whole_d;
    logic [6:0]    frac_q, frac_d;
    disp_t         disp_q, disp_d;
    logic [CW-1:0] refresh_q, refresh_d;
    logic [1:0]    digit_q, digit_d;
    logic [3:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;
    logic          dp_q, dp_d;

    logic       start;
    logic       done_w, done_f;
    logic [3:0] w_tens, w_ones, f_tens, f_ones;
    logic [3:0] digit_val;

    bin2bcd_seq u_bcd_whole (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .bin   (whole),
        .done  (done_w),
        .tens  (w_tens),
        .ones  (w_ones)
    );

    bin2bcd_seq u_bcd_frac (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .bin   (fracture),
        .done  (done_f),
        .tens  (f_tens),
        .ones  (f_ones)
    );

    always_comb begin
        state_d = state_q;
        busy_d  = busy_q;
        whole_d = whole_q;
        frac_d  = frac_q;
        disp_d  = disp_q;
        start   = 1'b0;
        case (state_q)
            IDLE: begin
                if (load) begin
                    state_d = CONV;
                    busy_d  = 1'b1;
                    whole_d = whole;
                    frac_d  = fracture;
                    start   = 1'b1;
                end
            end
            CONV: begin
                if (done_w && done_f) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    if (whole_q > 7'd99 || frac_q > 7'd99) begin
                        disp_d = '{ovf: 1'b1, default: 4'd0};
                    end else begin
                        disp_d = '{ovf: 1'b0, w_tens: w_tens, w_ones: w_ones,
                                   f_tens: f_tens, f_ones: f_ones};
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        refresh_d = refresh_q + 1'b1;
        digit_d   = digit_q;
        if (refresh_q == CW'(REFRESH_DIV - 1)) begin
            refresh_d = '0;
            digit_d   = digit_q + 2'd1;
        end
    end

    // Segment outputs are registered from the current digit index and display register
    always_comb begin
        an_d = ~(4'b0001 << digit_q);
        dp_d = 1'b1;
        case (digit_q)
            2'd3:    digit_val = disp_q.w_tens;
            2'd2:    begin digit_val = disp_q.w_ones; dp_d = 1'b0; end
            2'd1:    digit_val = disp_q.f_tens;
            default: digit_val = disp_q.f_ones;
        endcase
        seg_d = (digit_val <= 4'd9) ? SEG_DIGITS[digit_val] : SEG_BLANK;
`ifdef LEADING_ZERO_BLANK_EN
        if (digit_q == 2'd3 && disp_q.w_tens == 4'd0) begin
            seg_d = SEG_BLANK;
        end
`endif
        if (disp_q.ovf) begin
            seg_d = SEG_DASH;
            dp_d  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            whole_q   <= 7'd0;
            frac_q    <= 7'd0;
            disp_q    <= '0;
            refresh_q <= '0;
            digit_q   <= 2'd0;
            an_q      <= 4'b1110;
            seg_q     <= SEG_0;
            dp_q      <= 1'b1;
        end else begin
            state_q   <= state_d;
            busy_q    <= busy_d;
            whole_q   <= whole_d;
            frac_q    <= frac_d;
            disp_q    <= disp_d;
            refresh_q <= refresh_d;
            digit_q   <= digit_d;
            an_q      <= an_d;
            seg_q     <= seg_d;
            dp_q      <= dp_d;
        end
    end

    assign busy = busy_q;
    assign an   = an_q;
    assign seg  = seg_q;
    assign dp   = dp_q;

endmodule

// File: tb/tb_result_display.sv
// tb/tb_result_display.sv - scoreboard bench for result_display with REFRESH_DIV=4
module tb_result_display;

    logic       clk = 1'b0;
    logic       reset;
    logic       load;
    logic [6:0] whole;
    logic [6:0] fracture;
    logic       busy;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic [3:0][6:0] seg;
        logic [3:0]      dp;
    } exp_t;

    exp_t sb[$];
    exp_t shown;

    result_display #(.REFRESH_DIV(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .whole    (whole),
        .fracture (fracture),
        .busy     (busy),
        .seg      (seg),
        .dp       (dp),
        .an       (an)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] digit_seg(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic exp_t model(input int w, input int f);
        exp_t e;
        if (w > 99 || f > 99) begin
            for (int i = 0; i < 4; i++) e.seg[i] = 7'b0111111;
            e.dp = 4'b1111;
        end else begin
            e.seg[3] = digit_seg(w / 10);
`ifdef LEADING_ZERO_BLANK_EN
            if (w / 10 == 0) e.seg[3] = 7'h7F;
`endif
            e.seg[2] = digit_seg(w % 10);
            e.seg[1] = digit_seg(f / 10);
            e.seg[0] = digit_seg(f % 10);
            e.dp     = 4'b1011;
        end
        return e;
    endfunction

    function automatic int an_index(input logic [3:0] a);
        case (a)
            4'b1110: return 0;
            4'b1101: return 1;
            4'b1011: return 2;
            4'b0111: return 3;
            default: return -1;
        endcase
    endfunction

    task automatic check_cycle(input exp_t e, input string tag, output int idx);
        idx = an_index(an);
        check({tag, "_an_onehot"}, (idx >= 0), 1);
        if (idx >= 0) begin
            check($sformatf("%s_seg%0d", tag, idx), seg, e.seg[idx]);
            check($sformatf("%s_dp%0d", tag, idx), dp, e.dp[idx]);
        end
    endtask

    task automatic load_op(input int w, input int f, input bit push);
        @(negedge clk);
        whole = 7'(w); fracture = 7'(f); load = 1'b1;
        if (push) sb.push_back(model(w, f));
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic count_busy(input int expected);
        int n = 0;
        int idx;
        while (busy && n < 50) begin
            check_cycle(shown, "hold", idx);
            n++;
            @(negedge clk);
        end
        check("busy_cycles", n, expected);
    endtask

    task automatic scan_check(input string tag);
        int   prev = -1;
        int   idx;
        logic [3:0] seen = 4'b0000;
        if (sb.size() == 0) begin
            check({tag, "_sb_nonempty"}, 0, 1);
            return;
        end
        shown = sb.pop_front();
        for (int c = 0; c < 24; c++) begin
            check_cycle(shown, tag, idx);
            if (idx >= 0) begin
                if (prev >= 0 && idx != prev) check({tag, "_order"}, idx, (prev + 1) % 4);
                seen[idx] = 1'b1;
                prev = idx;
            end
            @(negedge clk);
        end
        check({tag, "_all_digits"}, seen, 4'hF);
    endtask

    initial begin
        reset = 1'b1; load = 1'b0; whole = '0; fracture = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("rst_an", an, 4'b1110);
        check("rst_seg", seg, 7'b1000000);
        check("rst_dp", dp, 1'b1);
        check("rst_busy", busy, 1'b0);
        sb.push_back(model(0, 0));
        scan_check("rst_scan");

        // 18.97 with an ignored load on the third busy cycle
        load_op(18, 97, 1'b1);
        check("busy_c1", busy, 1'b1);
        @(negedge clk);
        @(negedge clk);
        whole = 7'd5; fracture = 7'd0; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        count_busy(4);
        @(negedge clk);
        scan_check("d1897");

        load_op(120, 50, 1'b1);
        count_busy(7);
        @(negedge clk);
        scan_check("ovf");

        load_op(4, 0, 1'b1);
        count_busy(7);
        @(negedge clk);
        scan_check("d0400");

        // reset on the fourth busy cycle aborts the conversion
        load_op(33, 44, 1'b0);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check("abort_busy_before", busy, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_busy_after", busy, 1'b0);
        sb.push_back(model(0, 0));
        scan_check("abort_scan");

        load_op(42, 5, 1'b1);
        count_busy(7);
        @(negedge clk);
        scan_check("d4205");

        check("sb_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/result_display.md
RESULT_DISPLAY -- requirements
Module: result_display

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 100000, clock cycles each digit is held active; legal range 2 and up.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: the reset, synchronous and active-high.
REQ-004 SHALL have port load, input, 1 bit: one-cycle pulse that captures whole and fracture.
REQ-005 SHALL have port whole, input, 7 bits: integer part of the square-root result.
REQ-006 SHALL have port fracture, input, 7 bits: two-decimal fractional part, legal range 0..99.
REQ-007 SHALL have port busy, output, 1 bit: high while a conversion is in progress.
REQ-008 SHALL have port seg, output, 7 bits: active-low segments, with seg[0]=a through seg[6]=g.
REQ-009 SHALL have port dp, output, 1 bit: active-low decimal point.
REQ-010 SHALL have port an, output, 4 bits: active-low digit enables, with an[0] as the rightmost digit.

Function
REQ-011 SHALL use FSM states IDLE and CONV; IDLE goes to CONV on load, and CONV goes to IDLE after 7 conversion cycles.
REQ-012 SHALL capture whole and fracture on the load cycle; busy SHALL be high on the 7 cycles that follow.
REQ-013 SHALL update the display register on the cycle busy falls; the new digits SHALL drive seg from the next cycle.
REQ-014 SHALL ignore load while busy; the operands captured first SHALL be completed.
REQ-015 SHALL convert each operand to two BCD digits by iterative double-dabble, one shift per cycle, with both operands converted in parallel.
REQ-016 SHALL drive the digit map: an[3] = whole tens, an[2] = whole ones with dp low, an[1] = fracture tens, an[0] = fracture ones.
REQ-017 SHALL, if whole>99 or fracture>99, store the overflow pattern: dash (seg=7'b0111111) on all four digits and dp high.
REQ-018 SHALL run a refresh counter 0..REFRESH_DIV-1; on wrap, the digit index SHALL advance 0->1->2->3->0.
REQ-019 SHALL make exactly one an bit low at all times; seg and dp SHALL always match the active digit.
REQ-020 SHALL keep the previous display visible, unchanged and still scanning, during CONV.

Reset
REQ-021 SHALL, on reset, clear the FSM to IDLE, busy=0, refresh counter=0, digit index=0, and display register=00.00.
REQ-022 SHALL present an=4'b1110, seg=7'b1000000, dp=1 on the first cycle after reset.
REQ-023 SHALL, on reset during CONV, abort the conversion; busy SHALL be 0 on the next cycle and no partial result SHALL be stored.

Configuration
REQ-024 SHALL support macro LEADING_ZERO_BLANK_EN; when defined, a whole tens digit of 0 SHALL show blank (seg=7'h7F) with an[3] still scanned.
REQ-025 SHALL, when LEADING_ZERO_BLANK_EN is undefined, always show the whole tens digit, including 0; the overflow pattern SHALL be unaffected either way.

Structure
REQ-026 SHALL place these in shared package calc_pkg: the 7-segment encodings for 0-9, blank and dash, plus constants NUM_DIGITS=4 and CONV_CYCLES=7.
REQ-027 SHALL use sub-module bin2bcd_seq (7-bit to two-digit BCD, start/done handshake, 7 cycles), instantiated twice.
REQ-028 SHALL contain the FSM, display register, refresh counter, digit mux and segment decode in result_display itself.

Verification (REFRESH_DIV=4)
REQ-029 SHALL cover: reset held 2 cycles -> an=1110, seg=7'b1000000, dp=1, busy=0.
REQ-030 SHALL cover: load whole=18, fracture=97 -> busy high 7 cycles; scan then shows 7, 9, 8, 1 on an[0..3]; dp low only on an[2].
REQ-031 SHALL cover: load whole=5, fracture=0 on the 3rd busy cycle of REQ-030 -> ignored; final display 18.97.
REQ-032 SHALL cover: load whole=120, fracture=50 -> all digits 7'b0111111, dp=1 on every digit.
REQ-033 SHALL cover: load whole=4, fracture=0 -> an[3] seg=7'h7F with macro defined, 7'b1000000 without; remaining digits 4.00.
REQ-034 SHALL cover: reset on the 4th busy cycle -> busy=0 next cycle; display 00.00; a later load completes normally.
